// File: rtl/pwm_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_mixer_pkg
// Description : Shared definitions for the N-channel encoder-to-PWM mixer.
//               Holds the quadrature state codes ({a,b}), the direction
//               encoding produced by the decoder, a transition classifier and
//               a saturating step function.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_mixer_pkg;

    // Quadrature states, encoded as {a, b}
    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q01 = 2'b01;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q10 = 2'b10;

    // Decoder direction encoding
    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;

    // Classifies one {a,b} transition. No change and double-bit changes
    // (which carry no direction information) both return DIR_NONE.
    function automatic logic [1:0] quad_dir(input logic [1:0] prev,
                                            input logic [1:0] cur);
        logic [1:0] dir;
        dir = DIR_NONE;
        case ({prev, cur})
            {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: dir = DIR_UP;
            {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: dir = DIR_DOWN;
            default:                                        dir = DIR_NONE;
        endcase
        return dir;
    endfunction

    // Saturating step of a width-bit level. Comparisons are arranged so the
    // intermediate values never overflow: the level clamps instead of wrapping.
    function automatic logic [31:0] sat_step(input logic [31:0] level,
                                             input logic [31:0] step,
                                             input int          width,
                                             input logic [1:0]  dir);
        logic [31:0] max_v;
        logic [31:0] res;
        max_v = (32'd1 << width) - 32'd1;
        res   = level;
        case (dir)
            DIR_UP:   res = (level > (max_v - step)) ? max_v : (level + step);
            DIR_DOWN: res = (level < step) ? 32'd0 : (level - step);
            default:  res = level;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mixer_channel.sv
`default_nettype none
// ============================================================================
// Module      : mixer_channel
// Description : One mixer channel: debounces both encoder lines, decodes
//               quadrature transitions into a saturating level, and drives a
//               registered PWM output from a duty register that reloads only
//               when the supplied phase reaches its maximum.
// Ports       : clk, reset (async, active-high)
//               i_enc_a, i_enc_b  raw encoder lines
//               i_phase           this channel's PWM phase
//               o_pwm             registered PWM output
//               o_level           current level
// Revision    : 1.0 - initial release
// ============================================================================
module mixer_channel
    import pwm_mixer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HIST_LEN = 8,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enc_a,
    input  logic             i_enc_b,
    input  logic [WIDTH-1:0] i_phase,
    output logic             o_pwm,
    output logic [WIDTH-1:0] o_level
);

    localparam logic [WIDTH-1:0] c_phase_max = '1;

    // Index 1 is line A, index 0 is line B, so r_deb reads directly as {a,b}.
    logic [1:0]                 w_raw;
    logic [1:0][HIST_LEN-1:0]   r_hist;
    logic [1:0]                 r_deb;
    logic [1:0]                 r_prev;
    logic [1:0]                 w_dir;
    logic [WIDTH-1:0]           r_level;
    logic [WIDTH-1:0]           w_level_next;
    logic [WIDTH-1:0]           r_duty;
    logic                       r_pwm;

    assign w_raw = {i_enc_a, i_enc_b};

    // Debounce: the output only moves once the whole history agrees, so a
    // raw pulse shorter than HIST_LEN samples is invisible downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_deb  <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                r_hist[j] <= {r_hist[j][HIST_LEN-2:0], w_raw[j]};
                if (&r_hist[j]) begin
                    r_deb[j] <= 1'b1;
                end else if (~|r_hist[j]) begin
                    r_deb[j] <= 1'b0;
                end
            end
        end
    end

    assign w_dir        = quad_dir(r_prev, r_deb);
    assign w_level_next = WIDTH'(sat_step(32'(r_level), 32'(STEP), WIDTH, w_dir));

    // The previous state always tracks the debounced lines, including across
    // an ignored double-bit change, so decoding resynchronises immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev  <= Q00;
            r_level <= '0;
            r_duty  <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_prev  <= r_deb;
            r_level <= w_level_next;
            // Reload only at the period boundary so a running period is
            // never reshaped by a mid-period level change.
            if (i_phase == c_phase_max) begin
                r_duty <= r_level;
            end
            r_pwm <= (i_phase < r_duty);
        end
    end

    assign o_pwm   = r_pwm;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/pwm_mixer_n.sv
`default_nettype none
// ============================================================================
// Module      : pwm_mixer_n
// Description : N-channel quadrature-encoder to PWM mixer. Holds the shared
//               free-running PWM counter, the optional per-channel phase
//               stagger and one mixer_channel per channel.
//               Build option: define PWM_MIXER_STAGGER_EN to offset channel i
//               by i*(2^WIDTH/CHANNELS) counts, spreading rising edges over
//               the period. Undefined: all channels use the raw counter.
// Ports       : clk, reset (async, active-high)
//               enc_a, enc_b  [CHANNELS]        raw encoder lines
//               pwm_out       [CHANNELS]        registered PWM outputs
//               level_out     [CHANNELS*WIDTH]  level of channel i at
//                                               [i*WIDTH +: WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_mixer_n
    import pwm_mixer_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int HIST_LEN = 8,
    parameter int STEP     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*WIDTH-1:0] level_out
);

    logic [WIDTH-1:0] r_counter;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter <= '0;
        end else begin
            r_counter <= r_counter + WIDTH'(1);
        end
    end

`ifdef PWM_MIXER_STAGGER_EN
    localparam int c_stagger = (1 << WIDTH) / CHANNELS;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        logic [WIDTH-1:0] w_phase;

`ifdef PWM_MIXER_STAGGER_EN
        // Modulo wrap comes for free from the WIDTH-bit addition.
        assign w_phase = r_counter + WIDTH'(i * c_stagger);
`else
        assign w_phase = r_counter;
`endif

        mixer_channel #(
            .WIDTH    (WIDTH),
            .HIST_LEN (HIST_LEN),
            .STEP     (STEP)
        ) u_channel (
            .clk      (clk),
            .reset    (reset),
            .i_enc_a  (enc_a[i]),
            .i_enc_b  (enc_b[i]),
            .i_phase  (w_phase),
            .o_pwm    (pwm_out[i]),
            .o_level  (level_out[i*WIDTH +: WIDTH])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_mixer_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_mixer_n
// Description : Directed self-checking bench for pwm_mixer_n. The main
//               instance uses the default 3x8-bit configuration; a second
//               single-channel instance (HIST_LEN=2, STEP=8) allows large
//               level jumps within one PWM period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_mixer_n;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [2:0]  enc_a  = '0;
    logic [2:0]  enc_b  = '0;
    logic [2:0]  pwm_out;
    logic [23:0] level_out;
    logic [0:0]  enc_a2 = '0;
    logic [0:0]  enc_b2 = '0;
    logic [0:0]  pwm2;
    logic [7:0]  level2;

    int checks = 0;
    int errors = 0;
    int q_idx [3] = '{0, 0, 0};
    int q_idx2 = 0;
    logic [7:0] tb_cnt;

    pwm_mixer_n #(.CHANNELS(3), .WIDTH(8), .HIST_LEN(8), .STEP(1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .pwm_out   (pwm_out),
        .level_out (level_out)
    );

    pwm_mixer_n #(.CHANNELS(1), .WIDTH(8), .HIST_LEN(2), .STEP(8)) u_dut_fast (
        .clk       (clk),
        .reset     (reset),
        .enc_a     (enc_a2),
        .enc_b     (enc_b2),
        .pwm_out   (pwm2),
        .level_out (level2)
    );

    always #5 clk = ~clk;

    // Reference model of the shared PWM counter
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cnt <= 8'd0;
        else       tb_cnt <= tb_cnt + 8'd1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [1:0] qcode(input int idx);
        case (idx & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic drive_main();
        logic [1:0] q;
        for (int c = 0; c < 3; c++) begin
            q        = qcode(q_idx[c]);
            enc_a[c] = q[1];
            enc_b[c] = q[0];
        end
    endtask

    task automatic step(input int ch, input int dir, input int hold);
        q_idx[ch] = (q_idx[ch] + dir + 4) % 4;
        drive_main();
        tick(hold);
    endtask

    task automatic step2(input int dir);
        logic [1:0] q;
        q_idx2    = (q_idx2 + dir + 4) % 4;
        q         = qcode(q_idx2);
        enc_a2[0] = q[1];
        enc_b2[0] = q[0];
        tick(4);
    endtask

    // Settles one period, aligns to counter wrap, then counts high cycles
    // of one full period (samples reflecting phases 0..255).
    task automatic count_high(input int ch, output int n);
        int guard;
        n = 0;
        tick(256);
        guard = 0;
        while (tb_cnt != 8'd0 && guard < 300) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 256; i++) begin
            tick();
            n += int'(pwm_out[ch]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            enc_a  = 3'($urandom);
            enc_b  = 3'($urandom);
            enc_a2 = 1'($urandom);
            enc_b2 = 1'($urandom);
            tick();
            checks++;
            if (pwm_out !== 3'b000 || pwm2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_pwm: pwm_out=%b pwm2=%b expected 0", pwm_out, pwm2);
            end
            checks++;
            if (level_out !== 24'd0 || level2 !== 8'd0) begin
                errors++;
                $display("FAIL reset_level: level_out=%h level2=%h expected 0", level_out, level2);
            end
        end
        enc_a  = '0;
        enc_b  = '0;
        enc_a2 = '0;
        enc_b2 = '0;
        @(posedge clk);
        #3 reset = 1'b0;
        tick(30);
        checks++;
        if (pwm_out !== 3'b000 || level_out !== 24'd0) begin
            errors++;
            $display("FAIL post_reset_idle: pwm_out=%b level_out=%h expected 0", pwm_out, level_out);
        end
    endtask

    task automatic test_forward();
        int n;
        // First transition 00->01: debounced at k+8, level at k+9
        q_idx[0] = 1;
        drive_main();
        tick(9);
        checks++;
        if (level_out[7:0] !== 8'd0) begin
            errors++;
            $display("FAIL fwd_latency_early: level=%0d expected 0", level_out[7:0]);
        end
        tick(1);
        checks++;
        if (level_out[7:0] !== 8'd1) begin
            errors++;
            $display("FAIL fwd_latency_edge: level=%0d expected 1", level_out[7:0]);
        end
        tick(6);
        step(0, 1, 16);
        step(0, 1, 16);
        step(0, 1, 16);
        checks++;
        if (level_out !== 24'h000004) begin
            errors++;
            $display("FAIL fwd_detent_levels: level_out=%h expected 000004", level_out);
        end
        count_high(0, n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL fwd_pwm_duty: high=%0d expected 4", n);
        end
        count_high(1, n);
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL level0_const_low: high=%0d expected 0", n);
        end
    endtask

    task automatic test_glitch();
        enc_a[1] = 1'b1;
        tick(5);
        enc_a[1] = 1'b0;
        tick(3);
        repeat (20) begin
            enc_a[1] = 1'b1;
            tick(1);
            enc_a[1] = 1'b0;
            tick(1);
        end
        tick(12);
        checks++;
        if (level_out !== 24'h000004) begin
            errors++;
            $display("FAIL glitch_reject: level_out=%h expected 000004", level_out);
        end
    endtask

    task automatic test_invalid();
        // Direct 00->11 carries no direction and must be ignored
        q_idx[1] = 2;
        drive_main();
        tick(12);
        checks++;
        if (level_out[15:8] !== 8'd0) begin
            errors++;
            $display("FAIL invalid_ignored: level=%0d expected 0", level_out[15:8]);
        end
        step(1, 1, 12);
        checks++;
        if (level_out[15:8] !== 8'd1) begin
            errors++;
            $display("FAIL invalid_resync: level=%0d expected 1", level_out[15:8]);
        end
        step(1, 1, 12);
        checks++;
        if (level_out[15:8] !== 8'd2) begin
            errors++;
            $display("FAIL invalid_resync2: level=%0d expected 2", level_out[15:8]);
        end
    endtask

    task automatic test_saturation();
        int n;
        for (int i = 0; i < 4; i++) begin
            step(2, -1, 10);
            checks++;
            if (level_out[23:16] !== 8'd0) begin
                errors++;
                $display("FAIL sat_low: level=%0d expected 0", level_out[23:16]);
            end
        end
        repeat (250) step(2, 1, 10);
        checks++;
        if (level_out[23:16] !== 8'd250) begin
            errors++;
            $display("FAIL sat_ramp: level=%0d expected 250", level_out[23:16]);
        end
        repeat (5) step(2, 1, 10);
        checks++;
        if (level_out[23:16] !== 8'd255) begin
            errors++;
            $display("FAIL sat_exact_max: level=%0d expected 255", level_out[23:16]);
        end
        repeat (3) step(2, 1, 10);
        checks++;
        if (level_out !== {8'd255, 8'd2, 8'd4}) begin
            errors++;
            $display("FAIL sat_high: level_out=%h expected ff0204", level_out);
        end
        count_high(2, n);
        checks++;
        if (n != 255) begin
            errors++;
            $display("FAIL sat_pwm_duty: high=%0d expected 255", n);
        end
    endtask

    task automatic test_glitch_free();
        int n1;
        int n2;
        repeat (8) step2(1);
        tick(1);
        checks++;
        if (level2 !== 8'd64) begin
            errors++;
            $display("FAIL gf_setup: level=%0d expected 64", level2);
        end
        do tick(); while (tb_cnt != 8'd0);
        n1 = 0;
        n2 = 0;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    tick();
                    n1 += int'(pwm2[0]);
                end
                for (int i = 0; i < 256; i++) begin
                    tick();
                    n2 += int'(pwm2[0]);
                end
            end
            begin
                while (tb_cnt != 8'd30) tick();
                repeat (17) step2(1);
            end
        join
        checks++;
        if (n1 != 64) begin
            errors++;
            $display("FAIL gf_current_period: high=%0d expected 64", n1);
        end
        checks++;
        if (n2 != 200) begin
            errors++;
            $display("FAIL gf_next_period: high=%0d expected 200", n2);
        end
        checks++;
        if (level2 !== 8'd200) begin
            errors++;
            $display("FAIL gf_level: level=%0d expected 200", level2);
        end
    endtask

    task automatic test_stagger();
        logic [2:0] prev;
        int rise [3];
        int exp_rise [3];
        for (int s = 0; s < 127; s++) begin
            if (s < 124) q_idx[0] = (q_idx[0] + 1) % 4;
            if (s < 126) q_idx[1] = (q_idx[1] + 1) % 4;
            q_idx[2] = (q_idx[2] + 3) % 4;
            drive_main();
            tick(10);
        end
        checks++;
        if (level_out !== 24'h808080) begin
            errors++;
            $display("FAIL stagger_levels: level_out=%h expected 808080", level_out);
        end
        tick(512);
`ifdef PWM_MIXER_STAGGER_EN
        exp_rise = '{1, 172, 87};
`else
        exp_rise = '{1, 1, 1};
`endif
        rise = '{-1, -1, -1};
        prev = pwm_out;
        for (int i = 0; i < 256; i++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                if (!prev[c] && pwm_out[c] && rise[c] < 0) rise[c] = int'(tb_cnt);
            end
            prev = pwm_out;
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rise[c] != exp_rise[c]) begin
                errors++;
                $display("FAIL stagger_rise_ch%0d: rise_at=%0d expected %0d", c, rise[c], exp_rise[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int first;
        enc_a  = '0;
        enc_b  = '0;
        enc_a2 = '0;
        enc_b2 = '0;
        tick(12);
        guard = 0;
        while (!(pwm_out[0] && pwm2[0]) && guard < 600) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 600) begin
            errors++;
            $display("FAIL reset_mid_setup: pwm_out=%b pwm2=%b expected both active", pwm_out, pwm2);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (pwm_out !== 3'b000 || pwm2 !== 1'b0 || level_out !== 24'd0 || level2 !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_async: pwm_out=%b pwm2=%b level_out=%h level2=%h expected 0",
                     pwm_out, pwm2, level_out, level2);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        q_idx2    = 1;
        enc_a2[0] = 1'b0;
        enc_b2[0] = 1'b1;
        first = -1;
        for (int e = 1; e <= 600; e++) begin
            @(posedge clk);
            #1;
            if (pwm2[0] && first < 0) first = e;
        end
        checks++;
        if (first != 257) begin
            errors++;
            $display("FAIL counter_restart: first_high_edge=%0d expected 257", first);
        end
        checks++;
        if (level2 !== 8'd8 || level_out !== 24'd0 || pwm_out !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_state: level2=%0d level_out=%h pwm_out=%b expected 8/0/0",
                     level2, level_out, pwm_out);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_glitch();
        test_invalid();
        test_saturation();
        test_glitch_free();
        test_stagger();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
